// File: rtl/segdecode_pkg.sv
// Shared definitions for the SegDecode SPI initiator: FSM states, frame
// field positions, frame length and a frame composition helper.
package segdecode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_HOLD     = 3'd4,
        ST_SETTLE   = 3'd5
    } seg_state_e;

    localparam int COL_MSB = 7;
    localparam int COL_LSB = 6;
    localparam int SCR_MSB = 5;
    localparam int SCR_LSB = 4;
    localparam int DIG_MSB = 3;
    localparam int DIG_LSB = 0;

    localparam int PHASES_PER_FRAME = 19;
    localparam int DEFAULT_CLK_DIV  = 4;

    // Builds a command frame from keypad column, screen select and hex digit.
    function automatic logic [7:0] compose_frame(input logic [1:0] col,
                                                 input logic [1:0] scr,
                                                 input logic [3:0] dig);
        logic [7:0] frame;
        frame                  = 8'h00;
        frame[COL_MSB:COL_LSB] = col;
        frame[SCR_MSB:SCR_LSB] = scr;
        frame[DIG_MSB:DIG_LSB] = dig;
        return frame;
    endfunction

endpackage

// File: rtl/segdecode_autoscan.sv
// Autoscan helper: walks the four screens/columns, composes the frame for
// the current index and records the keypad result of each scan frame.
// Only instantiated when SEGDECODE_AUTOSCAN_EN is defined.
module segdecode_autoscan
    import segdecode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [15:0] digits,
    input  logic        scan_accept,
    input  logic        done,
    input  logic        key_n,
    output logic        scan_req,
    output logic [7:0]  scan_byte,
    output logic [3:0]  key_state
);

    logic [1:0] idx_r;
    logic       pending_r;
    logic [3:0] key_state_r;
    logic       frame_done_s;
    logic [1:0] idx_s;
    logic [3:0] digit_s;

    // A scan frame finishing advances the index in the same cycle, so a frame
    // accepted on the done cycle already uses the next index.
    always_comb begin
        frame_done_s = done & pending_r;
        if (frame_done_s) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end
    end

    // Select the hex digit belonging to the index being issued.
    always_comb begin
        digit_s = 4'h0;
        case (idx_s)
            2'd0:    digit_s = digits[3:0];
            2'd1:    digit_s = digits[7:4];
            2'd2:    digit_s = digits[11:8];
            2'd3:    digit_s = digits[15:12];
            default: digit_s = 4'h0;
        endcase
    end

    assign scan_req  = scan_en;
    assign scan_byte = compose_frame(idx_s, idx_s, digit_s);
    assign key_state = key_state_r;

    // Index, in-flight flag and pressed-key capture (active-high pressed).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r       <= 2'd0;
            pending_r   <= 1'b0;
            key_state_r <= 4'h0;
        end else begin
            idx_r <= idx_s;
            if (frame_done_s) begin
                key_state_r[idx_r] <= ~key_n;
            end
            if (scan_accept) begin
                pending_r <= 1'b1;
            end else if (frame_done_s) begin
                pending_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/segdecode_spi_master.sv
// SPI initiator for the SegDecode display/keypad chip. Sends one 8-bit
// frame MSB-first framed by en, then samples the keypad return on miso.
// Optional feature macro: SEGDECODE_AUTOSCAN_EN (adds the screen scanner).
module segdecode_spi_master
    import segdecode_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic       key_n,
    output logic       sck,
    output logic       mosi,
    output logic       en,
    input  logic       miso
`ifdef SEGDECODE_AUTOSCAN_EN
    ,
    input  logic        scan_en,
    input  logic [15:0] digits,
    output logic [3:0]  key_state
`endif
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    seg_state_e state_r, state_s;
    logic [7:0] phase_r, phase_s;
    logic [6:0] shift_r, shift_s;
    logic [2:0] bitcnt_r, bitcnt_s;
    logic       sck_r, sck_s;
    logic       mosi_r, mosi_s;
    logic       en_r, en_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       key_n_r, key_n_s;
    logic       phase_last_s;
    logic       accept_s;
    logic [7:0] accept_byte_s;

`ifdef SEGDECODE_AUTOSCAN_EN
    logic       scan_req_s;
    logic [7:0] scan_byte_s;
    logic       scan_accept_s;

    segdecode_autoscan u_autoscan (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .digits      (digits),
        .scan_accept (scan_accept_s),
        .done        (done_r),
        .key_n       (key_n_r),
        .scan_req    (scan_req_s),
        .scan_byte   (scan_byte_s),
        .key_state   (key_state)
    );
`endif

    assign phase_last_s = (phase_r == PHASE_LAST);

    // Frame acceptance in IDLE; an external start beats a scan request.
    always_comb begin
        accept_s      = 1'b0;
        accept_byte_s = tx_byte;
`ifdef SEGDECODE_AUTOSCAN_EN
        scan_accept_s = 1'b0;
`endif
        if (state_r == ST_IDLE) begin
            if (start) begin
                accept_s      = 1'b1;
                accept_byte_s = tx_byte;
            end
`ifdef SEGDECODE_AUTOSCAN_EN
            else if (scan_req_s) begin
                accept_s      = 1'b1;
                accept_byte_s = scan_byte_s;
                scan_accept_s = 1'b1;
            end
`endif
            else begin
                accept_s = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Single phase counter: every non-IDLE state lasts CLK_DIV cycles.
    always_comb begin
        if (state_r == ST_IDLE) begin
            phase_s = 8'd0;
        end else if (phase_last_s) begin
            phase_s = 8'd0;
        end else begin
            phase_s = phase_r + 8'd1;
        end
    end

    // Next state and next values of the registered SPI outputs.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        bitcnt_s = bitcnt_r;
        sck_s    = sck_r;
        mosi_s   = mosi_r;
        en_s     = en_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        key_n_s  = key_n_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_s  = accept_byte_s[6:0];
                    mosi_s   = accept_byte_s[7];
                    bitcnt_s = 3'd7;
                    en_s     = 1'b1;
                    busy_s   = 1'b1;
                    sck_s    = 1'b0;
                    state_s  = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_last_s) begin
                    state_s = ST_SHIFT_LO;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_last_s) begin
                    sck_s   = 1'b1;
                    state_s = ST_SHIFT_HI;
                end else begin
                    state_s = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_last_s) begin
                    sck_s = 1'b0;
                    if (bitcnt_r == 3'd0) begin
                        state_s = ST_HOLD;
                    end else begin
                        mosi_s   = shift_r[6];
                        shift_s  = {shift_r[5:0], 1'b0};
                        bitcnt_s = bitcnt_r - 3'd1;
                        state_s  = ST_SHIFT_LO;
                    end
                end else begin
                    state_s = ST_SHIFT_HI;
                end
            end
            ST_HOLD: begin
                if (phase_last_s) begin
                    en_s    = 1'b0;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_SETTLE: begin
                if (phase_last_s) begin
                    key_n_s = miso;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    mosi_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sck_s   = 1'b0;
                mosi_s  = 1'b0;
                en_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns the bus to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            phase_r  <= 8'd0;
            shift_r  <= 7'd0;
            bitcnt_r <= 3'd0;
            sck_r    <= 1'b0;
            mosi_r   <= 1'b0;
            en_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            key_n_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            phase_r  <= phase_s;
            shift_r  <= shift_s;
            bitcnt_r <= bitcnt_s;
            sck_r    <= sck_s;
            mosi_r   <= mosi_s;
            en_r     <= en_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            key_n_r  <= key_n_s;
        end
    end

    assign sck   = sck_r;
    assign mosi  = mosi_r;
    assign en    = en_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign key_n = key_n_r;

endmodule

// File: tb/tb_segdecode_spi_master.sv
// Self-checking bench for segdecode_spi_master: keypad slave model,
// scoreboard of expected frames and a negedge monitor.
module tb_segdecode_spi_master;

    localparam int CD    = 2;
    localparam int FRAME = 19 * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx = 8'h00;
    logic       miso = 1'b1;
    logic       busy, done, key_n, sck, mosi, en;

    logic       start1 = 1'b0;
    logic [7:0] tx1 = 8'h00;
    logic       miso1 = 1'b1;
    logic       busy1, done1, key_n1, sck1, mosi1, en1;

`ifdef SEGDECODE_AUTOSCAN_EN
    logic        scan_en = 1'b0;
    logic [15:0] digits = 16'h4321;
    logic [3:0]  key_state;
    logic        scan_en1 = 1'b0;
    logic [3:0]  key_state1;
    logic [1:0]  m_idx = 2'd0;
`endif

    segdecode_spi_master #(.CLK_DIV(CD)) u_dut (
        .clk(clk), .rst(rst), .start(start), .tx_byte(tx),
        .busy(busy), .done(done), .key_n(key_n),
        .sck(sck), .mosi(mosi), .en(en), .miso(miso)
`ifdef SEGDECODE_AUTOSCAN_EN
        , .scan_en(scan_en), .digits(digits), .key_state(key_state)
`endif
    );

    segdecode_spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_byte(tx1),
        .busy(busy1), .done(done1), .key_n(key_n1),
        .sck(sck1), .mosi(mosi1), .en(en1), .miso(miso1)
`ifdef SEGDECODE_AUTOSCAN_EN
        , .scan_en(scan_en1), .digits(digits), .key_state(key_state1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Keypad slave: shifts on sck rise while en, latches on en fall and
    // returns the inverted key state of the addressed column.
    logic [7:0] sl_sreg = 8'h00;
    logic [3:0] pressed = 4'h0;
    initial forever begin
        @(posedge sck);
        if (en) sl_sreg = {sl_sreg[6:0], mosi};
    end
    initial forever begin
        @(negedge en);
        miso = ~pressed[sl_sreg[7:6]];
    end

    // Scoreboard entries: frame byte, expected key_n, accepting cycle.
    typedef struct {
        logic [7:0] b;
        logic       kn;
        int         acc;
    } exp_t;
    exp_t sb[$];

    int         cur_acc = -100000;
    int         rises = 0;
    int         first_rise = -1;
    int         en_fall = -1;
    int         mosi_chg = -100000;
    logic [7:0] rx = 8'h00;
    logic       sck_prev = 1'b0, en_prev = 1'b0, mosi_prev = 1'b0;

    task automatic push_exp(input logic [7:0] b);
        exp_t e;
        e.b   = b;
        e.kn  = ~pressed[b[7:6]];
        e.acc = cyc + 1;
        sb.push_back(e);
        cur_acc    = cyc + 1;
        rises      = 0;
        rx         = 8'h00;
        first_rise = -1;
        en_fall    = -1;
    endtask

    // Monitor: checks busy window, bus timing and completed frames, and
    // predicts acceptance of the next frame from what the host presents.
    initial forever begin
        exp_t e;
        logic exp_busy;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            cur_acc = -100000;
            rises   = 0;
`ifdef SEGDECODE_AUTOSCAN_EN
            m_idx   = 2'd0;
`endif
        end else begin
            exp_busy = (cyc >= cur_acc) && (cyc < cur_acc + FRAME);
            check("busy", busy, exp_busy);
            if (mosi !== mosi_prev) mosi_chg = cyc;
            if (sck && !sck_prev) begin
                if (rises == 0) first_rise = cyc;
                rx = {rx[6:0], mosi};
                rises++;
                check("mosi_setup_ok", (cyc - mosi_chg) >= CD, 1);
            end
            if (!en && en_prev) en_fall = cyc;
            if (done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    check("frame_bits", rx, e.b);
                    check("sck_rises", rises, 8);
                    check("key_n", key_n, e.kn);
                    check("done_latency", cyc - e.acc, FRAME);
                    check("en_to_first_sck", first_rise - e.acc, 2 * CD);
                    check("en_fall_time", en_fall - e.acc, 18 * CD);
                end
            end
            if (!busy) begin
                if (start) begin
                    push_exp(tx);
                end
`ifdef SEGDECODE_AUTOSCAN_EN
                else if (scan_en) begin
                    push_exp({m_idx, m_idx, digits[m_idx*4 +: 4]});
                    m_idx = m_idx + 2'd1;
                end
`endif
            end
        end
        sck_prev  = sck;
        en_prev   = en;
        mosi_prev = mosi;
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 4 * FRAME) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) fail_now("timeout_idle");
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 2 * FRAME) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) fail_now("timeout_done");
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle();
        @(posedge clk); #1;
        start = 1'b1;
        tx    = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r, k, n;
        logic       sp;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_key_n", key_n, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame, no key pressed.
        pressed = 4'h0;
        send(8'hA5);

        // Column 1 pressed, then column 0 idle.
        pressed = 4'b0010;
        send(8'h40);
        send(8'h00);
        pressed = 4'h0;

        // start while busy is ignored.
        wait_idle();
        @(posedge clk); #1;
        start = 1'b1; tx = 8'h96;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; tx = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;

        // start held through done: back-to-back frames.
        wait_idle();
        @(posedge clk); #1;
        start = 1'b1; tx = 8'h3A;
        @(posedge clk); #1;
        tx = 8'hC5;
        wait_done();
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        @(posedge clk); #1;

        // Reset during SHIFT_HI of bit 3.
        wait_idle();
        @(posedge clk); #1;
        start = 1'b1; tx = 8'hC3;
        @(posedge clk); #1;
        start = 1'b0;
        r = 0; k = 0; sp = sck;
        while (r < 5 && k < 4 * FRAME) begin
            @(posedge clk); #1;
            if (sck && !sp) r++;
            sp = sck;
            k++;
        end
        check("reset_point_reached", r, 5);
        rst = 1'b1;
        #1;
        check("midrst_sck", sck, 0);
        check("midrst_en", en, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_key_n", key_n, 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(8'h3C);

        // Randomised frames with random key patterns.
        for (int i = 0; i < 20; i++) begin
            pressed = 4'($urandom_range(0, 15));
            b       = 8'($urandom_range(0, 255));
            send(b);
        end
        pressed = 4'h0;

        // CLK_DIV=1 instance: single-cycle phases.
        @(posedge clk); #1;
        start1 = 1'b1; tx1 = 8'hFF;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0; r = 0; b = 8'h00; sp = sck1;
        while (!done1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (sck1 && !sp) begin
                r++;
                b = {b[6:0], mosi1};
            end
            sp = sck1;
        end
        check("cd1_done_cycle", n, 19);
        check("cd1_rises", r, 8);
        check("cd1_bits", b, 8'hFF);
        check("cd1_busy_at_done", busy1, 0);
        check("cd1_key_n", key_n1, 1);

`ifdef SEGDECODE_AUTOSCAN_EN
        // Autoscan: two full rounds with column 2 pressed.
        wait_idle();
        pressed = 4'b0100;
        digits  = 16'h4321;
        @(posedge clk); #1;
        scan_en = 1'b1;
        n = 0; k = 0;
        while (n < 8 && k < 10 * FRAME) begin
            @(posedge clk); #1;
            if (done) n++;
            k++;
        end
        scan_en = 1'b0;
        check("scan_frames", n, 8);
        @(posedge clk); #1;
        check("key_state", key_state, 4'b0100);
        wait_idle();
        pressed = 4'h0;
`endif

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
